// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL sequencer over one shared (WIDTH+1)-bit adder.
// Define CALC_SEQ_MUL_EN to compile in the shift-add multiplier; otherwise op 10 is illegal.
module calc_op_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2*WIDTH-1:0] res_o
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_LOOP, DONE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   a_r, b_r;
  logic [1:0]         op_r;
  logic [WIDTH:0]     add_x, add_y, add_sum;
  logic               add_cin;
  logic               load_res;
  logic               err_n;
  logic [2*WIDTH-1:0] res_n;

`ifdef CALC_SEQ_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  // Upper half accumulates partial sums; lower half holds the not-yet-consumed multiplier bits.
  logic [2*WIDTH-1:0] prod, prod_n;
`endif

  assign add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

  // Operand select for the shared adder; SUB uses a + ~b + 1 over WIDTH+1 bits.
  always_comb begin
    add_x   = {1'b0, a_r};
    add_y   = {1'b0, b_r};
    add_cin = 1'b0;
    if (state == EXEC && op_r == 2'b01) begin
      add_y   = ~{1'b0, b_r};
      add_cin = 1'b1;
    end
`ifdef CALC_SEQ_MUL_EN
    if (state == MUL_LOOP) begin
      add_x = {1'b0, prod[2*WIDTH-1:WIDTH]};
      add_y = prod[0] ? {1'b0, a_r} : '0;
    end
`endif
  end

  always_comb begin
    state_n  = state;
    load_res = 1'b0;
    res_n    = '0;
    err_n    = 1'b0;
`ifdef CALC_SEQ_MUL_EN
    prod_n   = {add_sum, prod[WIDTH-1:1]};
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
`ifdef CALC_SEQ_MUL_EN
          state_n = (op_i == 2'b10) ? MUL_LOOP : EXEC;
`else
          state_n = EXEC;
`endif
        end
      end
      EXEC: begin
        state_n  = DONE;
        load_res = 1'b1;
        if (!op_r[1]) res_n = {{(WIDTH-1){1'b0}}, add_sum};
        else          err_n = 1'b1;
      end
`ifdef CALC_SEQ_MUL_EN
      MUL_LOOP: begin
        if (cnt == LAST) begin
          state_n  = DONE;
          load_res = 1'b1;
          res_n    = prod_n;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      res_o  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
`ifdef CALC_SEQ_MUL_EN
      cnt    <= '0;
      prod   <= '0;
`endif
    end else begin
      state  <= state_n;
      busy_o <= (state_n == EXEC) || (state_n == MUL_LOOP);
      done_o <= (state_n == DONE);
      if (load_res) begin
        res_o <= res_n;
        err_o <= err_n;
      end
      if (state == IDLE && start_i) begin
        a_r  <= a_i;
        b_r  <= b_i;
        op_r <= op_i;
`ifdef CALC_SEQ_MUL_EN
        cnt  <= '0;
        prod <= {{WIDTH{1'b0}}, b_i};
`endif
      end
`ifdef CALC_SEQ_MUL_EN
      if (state == MUL_LOOP) begin
        cnt  <= cnt + CW'(1);
        prod <= prod_n;
      end
`endif
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer (WIDTH=8); MUL expectations follow CALC_SEQ_MUL_EN.
module tb_calc_op_sequencer;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, err;
  logic [2*W-1:0] res;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .res_o   (res)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_res",  {16'd0, res},  32'd0);
    rst = 1'b0;
    tick;

    // ADD 200+100; operands scrambled after acceptance must not matter
    req(2'b00, 8'd200, 8'd100);
    tick;
    start = 1'b0; a = 8'hAA; b = 8'h55; op = 2'b11;
    chk("add_c1_busy", {31'd0, busy}, 32'd1);
    chk("add_c1_done", {31'd0, done}, 32'd0);
    tick;
    chk("add_c2_done", {31'd0, done}, 32'd1);
    chk("add_c2_busy", {31'd0, busy}, 32'd0);
    chk("add_res",     {16'd0, res},  32'h012C);
    chk("add_err",     {31'd0, err},  32'd0);
    tick;
    chk("add_c3_done", {31'd0, done}, 32'd0);
    chk("add_hold",    {16'd0, res},  32'h012C);

    // SUB 5-10 borrows into bit 8
    req(2'b01, 8'd5, 8'd10);
    tick;
    start = 1'b0;
    tick;
    chk("sub1_done", {31'd0, done}, 32'd1);
    chk("sub1_res",  {16'd0, res},  32'h01FB);
    tick;
    req(2'b01, 8'd10, 8'd5);
    tick;
    start = 1'b0;
    tick;
    chk("sub2_done", {31'd0, done}, 32'd1);
    chk("sub2_res",  {16'd0, res},  32'h0005);
    tick;

`ifdef CALC_SEQ_MUL_EN
    // MUL 255*255; an ADD request in cycle 4 must be ignored
    req(2'b10, 8'd255, 8'd255);
    tick;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("mul_c%0d_busy", c), {31'd0, busy}, 32'd1);
      chk($sformatf("mul_c%0d_done", c), {31'd0, done}, 32'd0);
      if (c == 4) req(2'b00, 8'd1, 8'd1);
      tick;
      start = 1'b0;
    end
    chk("mul_c9_done", {31'd0, done}, 32'd1);
    chk("mul_c9_busy", {31'd0, busy}, 32'd0);
    chk("mul_res",     {16'd0, res},  32'hFE01);
    chk("mul_err",     {31'd0, err},  32'd0);
    for (int c = 10; c <= 13; c++) begin
      tick;
      chk($sformatf("mul_c%0d_done", c), {31'd0, done}, 32'd0);
      chk($sformatf("mul_c%0d_busy", c), {31'd0, busy}, 32'd0);
    end
`else
    // Without the multiplier op 10 is illegal
    req(2'b10, 8'd2, 8'd3);
    tick;
    start = 1'b0;
    chk("mulx_c1_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("mulx_done", {31'd0, done}, 32'd1);
    chk("mulx_err",  {31'd0, err},  32'd1);
    chk("mulx_res",  {16'd0, res},  32'd0);
    tick;
`endif

    // Reserved op, then a legal op clears err
    req(2'b11, 8'd3, 8'd4);
    tick;
    start = 1'b0;
    tick;
    chk("ill_done", {31'd0, done}, 32'd1);
    chk("ill_err",  {31'd0, err},  32'd1);
    chk("ill_res",  {16'd0, res},  32'd0);
    tick;
    req(2'b00, 8'd1, 8'd1);
    tick;
    start = 1'b0;
    tick;
    chk("add11_done", {31'd0, done}, 32'd1);
    chk("add11_err",  {31'd0, err},  32'd0);
    chk("add11_res",  {16'd0, res},  32'd2);
    tick;

    // Mid-operation reset, with a start request held during reset
`ifdef CALC_SEQ_MUL_EN
    req(2'b10, 8'd12, 8'd13);
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
`else
    req(2'b00, 8'd9, 8'd9);
    tick;
    start = 1'b0;
`endif
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    req(2'b00, 8'd50, 8'd50);
    tick;
    rst = 1'b0;
    start = 1'b0;
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    chk("postrst_done", {31'd0, done}, 32'd0);
    chk("postrst_err",  {31'd0, err},  32'd0);
    chk("postrst_res",  {16'd0, res},  32'd0);
    for (int c = 0; c < 12; c++) begin
      tick;
      chk($sformatf("postrst_quiet%0d", c), {31'd0, done | busy}, 32'd0);
    end

    req(2'b00, 8'd7, 8'd8);
    tick;
    start = 1'b0;
    chk("add78_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("add78_done", {31'd0, done}, 32'd1);
    chk("add78_res",  {16'd0, res},  32'd15);
    chk("add78_err",  {31'd0, err},  32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
